// File: rtl/obstacle_lane_if.sv
`default_nettype none
// ============================================================================
//  Module   : obstacle_lane_if
//  Brief    : Spawn handshake and pixel-scan bus of the obstacle lane.
//  Revision : 1.0 - initial release
// ============================================================================
interface obstacle_lane_if #(
    parameter int CORDW = 10,
    parameter int CIDXW = 3
);
    logic             spawn_valid;
    logic [1:0]       spawn_loc;
    logic             spawn_ready;
    logic [CORDW-1:0] hc;
    logic [CORDW-1:0] vc;
    logic [CIDXW:0]   pix;

    modport master (
        output spawn_valid,
        output spawn_loc,
        output hc,
        output vc,
        input  spawn_ready,
        input  pix
    );

    modport slave (
        input  spawn_valid,
        input  spawn_loc,
        input  hc,
        input  vc,
        output spawn_ready,
        output pix
    );
endinterface
`default_nettype wire

// File: rtl/obstacle_lane.sv
`default_nettype none
// ============================================================================
//  Module   : obstacle_lane
//  Brief    : NUM_OBS scrolling obstacle slots with spawn handshake, retire
//             counting and a registered colour-index pixel stream.
//  Revision : 1.0 - initial release
// ============================================================================
module obstacle_lane #(
    parameter int          NUM_OBS   = 4,
    parameter int          CIDXW     = 3,
    parameter int          CORDW     = 10,
    parameter int          OBS_W     = 20,
    parameter int          OBS_H     = 40,
    parameter int          X_START   = 780,
    parameter int          X_END     = 60,
    parameter int          MIN_GAP   = 120,
    parameter int          TICK_DIV  = 524288,
    parameter int          Y0        = 0,
    parameter int          Y1        = 160,
    parameter int          Y2        = 200,
    parameter int          Y3        = 250,
    parameter int unsigned OBS_COLOR = 4'b1000
) (
    input  wire logic           CLK,
    input  wire logic           RESET,
    input  wire logic           run,
    input  wire logic           clear,
    input  wire logic [7:0]     speed,
    obstacle_lane_if.slave      bus,
    output logic [NUM_OBS-1:0]  active,
    output logic                passed,
    output logic [7:0]          pass_count
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int c_XW = CORDW + 1;

    localparam logic [c_PW-1:0]  c_PRE_LAST  = c_PW'(TICK_DIV - 1);
    localparam logic [CORDW-1:0] c_X_START   = CORDW'(X_START);
    localparam logic [CORDW-1:0] c_SPAWN_LIM = CORDW'(X_START - MIN_GAP);
    localparam logic [c_XW-1:0]  c_X_END     = c_XW'(X_END);
    localparam logic [c_XW-1:0]  c_OBS_W1    = c_XW'(OBS_W - 1);
    localparam logic [c_XW-1:0]  c_OBS_H1    = c_XW'(OBS_H - 1);
    localparam logic [CIDXW:0]   c_COLOR     = (CIDXW+1)'(OBS_COLOR);

    logic [NUM_OBS-1:0] r_active;
    logic [CORDW-1:0]   r_x [NUM_OBS];
    logic [CORDW-1:0]   r_y [NUM_OBS];
    logic [c_PW-1:0]    r_pre;
    logic               r_passed;
    logic [7:0]         r_pass_count;
    logic [CIDXW:0]     r_pix;

    logic               w_tick;
    logic               w_spawn;
    logic [c_SW-1:0]    w_slot;
    logic               w_found;
    logic [CORDW-1:0]   w_yspawn;
    logic [c_XW-1:0]    w_ret_lim;
    logic [NUM_OBS-1:0] w_near;
    logic [NUM_OBS-1:0] w_ret;
    logic [NUM_OBS-1:0] w_hit;
    logic [3:0]         w_nret;
    logic [8:0]         w_pc_sum;
    logic [7:0]         w_pc_next;

    assign w_tick    = run & ~clear & (r_pre == c_PRE_LAST);
    assign w_ret_lim = c_X_END + c_XW'(speed);

    // Ready looks only at registered state; a slot freed this cycle is reusable next cycle.
    assign bus.spawn_ready = run & ~clear & ~(&r_active) & ~(|w_near);
    assign w_spawn         = bus.spawn_valid & bus.spawn_ready;

    generate
        for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
            logic [c_XW-1:0] w_x;
            logic [c_XW-1:0] w_y;
            logic [c_XW-1:0] w_hc;
            logic [c_XW-1:0] w_vc;

            assign w_x  = {1'b0, r_x[gi]};
            assign w_y  = {1'b0, r_y[gi]};
            assign w_hc = {1'b0, bus.hc};
            assign w_vc = {1'b0, bus.vc};

            assign w_near[gi] = r_active[gi] & (r_x[gi] > c_SPAWN_LIM);
            assign w_ret[gi]  = w_tick & r_active[gi] & (w_x <= w_ret_lim);
            assign w_hit[gi]  = r_active[gi]
                              & (w_x <= w_hc) & (w_hc <= w_x + c_OBS_W1)
                              & (w_y <= w_vc) & (w_vc <= w_y + c_OBS_H1);
        end
    endgenerate

    always_comb begin
        w_slot  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!r_active[i] && !w_found) begin
                w_slot  = c_SW'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_yspawn = CORDW'(Y0);
        case (bus.spawn_loc)
            2'd0:    w_yspawn = CORDW'(Y0);
            2'd1:    w_yspawn = CORDW'(Y1);
            2'd2:    w_yspawn = CORDW'(Y2);
            default: w_yspawn = CORDW'(Y3);
        endcase
    end

    always_comb begin
        w_nret = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            w_nret = w_nret + 4'(w_ret[i]);
        end
    end

    assign w_pc_sum  = {1'b0, r_pass_count} + 9'(w_nret);
    assign w_pc_next = w_pc_sum[8] ? 8'hFF : w_pc_sum[7:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_active     <= '0;
            r_pre        <= '0;
            r_passed     <= 1'b0;
            r_pass_count <= '0;
            r_pix        <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            // Drawing ignores run so a paused game keeps its obstacles on screen.
            r_pix <= (|w_hit) ? c_COLOR : '0;
            if (clear) begin
                r_active     <= '0;
                r_pre        <= '0;
                r_passed     <= 1'b0;
                r_pass_count <= '0;
            end else begin
                if (run) begin
                    r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PW'(1);
                end
                r_passed     <= |w_ret;
                r_pass_count <= w_pc_next;
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (w_ret[i]) begin
                        r_active[i] <= 1'b0;
                    end else if (w_tick && r_active[i]) begin
                        r_x[i] <= r_x[i] - CORDW'(speed);
                    end
                    // The chosen slot is inactive, so it never collides with a move above.
                    if (w_spawn && (w_slot == c_SW'(i))) begin
                        r_active[i] <= 1'b1;
                        r_x[i]      <= c_X_START;
                        r_y[i]      <= w_yspawn;
                    end
                end
            end
        end
    end

    assign active     = r_active;
    assign passed     = r_passed;
    assign pass_count = r_pass_count;
    assign bus.pix    = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_lane.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obstacle_lane
//  Brief    : Directed self-checking bench for obstacle_lane (TICK_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_lane;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       run;
    logic       clear;
    logic [7:0] speed;
    logic [3:0] active;
    logic       passed;
    logic [7:0] pass_count;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    obstacle_lane_if #(.CORDW(10), .CIDXW(3)) bus ();

    obstacle_lane #(
        .NUM_OBS  (4),
        .TICK_DIV (4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .run        (run),
        .clear      (clear),
        .speed      (speed),
        .bus        (bus.slave),
        .active     (active),
        .passed     (passed),
        .pass_count (pass_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Advance until n move ticks have taken effect; returns just after the last one.
    task automatic tick_n(input int n);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < 2000) begin
            if (dut.w_tick) seen++;
            step();
            guard++;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    task automatic spawn(input logic [1:0] loc);
        bus.spawn_valid = 1'b1;
        bus.spawn_loc   = loc;
        step();
        bus.spawn_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
    endtask

    initial begin
        int g;
        RESET = 1'b1; run = 1'b0; clear = 1'b0; speed = 8'd0;
        bus.spawn_valid = 1'b0; bus.spawn_loc = 2'd0; bus.hc = '0; bus.vc = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_active", active, 0);
        check("rst_pix", bus.pix, 0);
        check("rst_count", pass_count, 0);
        check("rst_passed", passed, 0);
        check("rst_ready", bus.spawn_ready, 0);
        check("rst_pre", dut.r_pre, 0);
        RESET = 1'b0;

        // 1: spawn in lane 2, move, draw
        run = 1'b1; speed = 8'd4;
        bus.spawn_valid = 1'b1; bus.spawn_loc = 2'd2;
        #1;
        check("t1_ready", bus.spawn_ready, 1);
        step();
        bus.spawn_valid = 1'b0;
        check("t1_active", active, 1);
        check("t1_x0", dut.r_x[0], 780);
        check("t1_y0", dut.r_y[0], 200);
        tick_n(3);
        check("t1_x3", dut.r_x[0], 768);
        bus.hc = 10'd770; bus.vc = 10'd210; step();
        check("t1_pix_in", bus.pix, 8);
        bus.hc = 10'd788; step();
        check("t1_pix_right_out", bus.pix, 0);
        bus.hc = 10'd787; step();
        check("t1_pix_right_edge", bus.pix, 8);
        bus.hc = 10'd767; step();
        check("t1_pix_left_out", bus.pix, 0);
        bus.hc = 10'd770; bus.vc = 10'd239; step();
        check("t1_pix_bottom_edge", bus.pix, 8);
        bus.vc = 10'd240; step();
        check("t1_pix_bottom_out", bus.pix, 0);

        // 2: speed 10 from 780 reaches 70 after 71 ticks, retires on the 72nd
        pulse_reset();
        speed = 8'd10;
        spawn(2'd0);
        tick_n(71);
        check("t2_x70", dut.r_x[0], 70);
        check("t2_still_active", active, 1);
        tick_n(1);
        check("t2_retired", active, 0);
        check("t2_passed", passed, 1);
        check("t2_count", pass_count, 1);
        step();
        check("t2_passed_drop", passed, 0);

        // 3: minimum gap and full slots
        bus.spawn_valid = 1'b1; bus.spawn_loc = 2'd3;
        step();
        bus.spawn_loc = 2'd1;
        check("t3_first", active, 1);
        check("t3_gap_ready", bus.spawn_ready, 0);
        tick_n(11);
        check("t3_x670", dut.r_x[0], 670);
        check("t3_ready_670", bus.spawn_ready, 0);
        check("t3_no_queue", active, 1);
        tick_n(1);
        check("t3_ready_660", bus.spawn_ready, 1);
        step();
        check("t3_second", active, 3);
        check("t3_x1", dut.r_x[1], 780);
        check("t3_y1", dut.r_y[1], 160);
        check("t3_y0", dut.r_y[0], 250);
        tick_n(12); step();
        tick_n(12); step();
        check("t3_full", active, 15);
        tick_n(12);
        check("t3_full_ready", bus.spawn_ready, 0);
        check("t3_x0_300", dut.r_x[0], 300);
        bus.spawn_valid = 1'b0;

        // 4: pause freezes position and tick phase, drawing continues
        pulse_reset();
        speed = 8'd10;
        spawn(2'd1);
        tick_n(12);
        check("t4_ready", bus.spawn_ready, 1);
        step(); step();
        run = 1'b0;
        #1;
        check("t4_paused_ready", bus.spawn_ready, 0);
        repeat (10) step();
        check("t4_x_frozen", dut.r_x[0], 660);
        check("t4_pre_frozen", dut.r_pre, 2);
        bus.hc = 10'd665; bus.vc = 10'd170; step();
        check("t4_pix_paused", bus.pix, 8);
        run = 1'b1;
        step();
        check("t4_no_tick_yet", dut.r_x[0], 660);
        step();
        check("t4_resumed_tick", dut.r_x[0], 650);

        // 5: drive the counter to 254, then a double retire saturates it
        clear = 1'b1; step(); clear = 1'b0;
        check("t5_cleared", pass_count, 0);
        speed = 8'd255;
        for (int k = 0; k < 254; k++) begin
            spawn(2'd0);
            g = 0;
            while (!passed && g < 100) begin step(); g++; end
            if (!passed) check("t5_wait_passed", passed, 1);
        end
        check("t5_count254", pass_count, 254);
        speed = 8'd130;
        spawn(2'd0);
        tick_n(1);
        check("t5_a650", dut.r_x[0], 650);
        spawn(2'd0);
        check("t5_two", active, 3);
        speed = 8'd255;
        tick_n(2);
        check("t5_a140", dut.r_x[0], 140);
        check("t5_b270", dut.r_x[1], 270);
        check("t5_hold254", pass_count, 254);
        tick_n(1);
        check("t5_double_gone", active, 0);
        check("t5_double_pass", passed, 1);
        check("t5_sat255", pass_count, 255);
        step();
        check("t5_single_pulse", passed, 0);
        spawn(2'd0);
        g = 0;
        while (!passed && g < 100) begin step(); g++; end
        check("t5_extra_passed", passed, 1);
        check("t5_stay255", pass_count, 255);

        // 6: clear beats spawn and tick; async reset clears pix mid-cycle
        spawn(2'd0);
        g = 0;
        while (dut.r_pre != 2'd3 && g < 20) begin step(); g++; end
        check("t6_pre_phase", dut.r_pre, 3);
        clear = 1'b1; bus.spawn_valid = 1'b1;
        #1;
        check("t6_ready_clear", bus.spawn_ready, 0);
        step();
        clear = 1'b0; bus.spawn_valid = 1'b0;
        check("t6_active", active, 0);
        check("t6_count", pass_count, 0);
        check("t6_passed", passed, 0);
        check("t6_pre", dut.r_pre, 0);
        spawn(2'd0);
        bus.hc = 10'd790; bus.vc = 10'd10;
        step();
        check("t6_pix_on", bus.pix, 8);
        #3;
        RESET = 1'b1;
        #1;
        check("t6_async_pix", bus.pix, 0);
        check("t6_async_active", active, 0);
        RESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
